mem_handshake_ctrl: RTL and testbench

- Parametrised successor to the team's single-port 16-bit data memory.
- Adds a valid/ready request/response handshake, a configurable read/write latency (wait states) and out-of-range address detection.
- Sits between the multi-cycle CPU datapath and the storage array, so the controller FSM can be exercised against slow memory.
- Storage array and FSM live in one block; storage is not reset.

---
 rtl/mem_handshake_pkg.sv | 13 +
 rtl/mem_array.sv | 24 ++
 rtl/mem_handshake_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_handshake_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_handshake_pkg.sv
// Shared types and default widths for the handshake memory controller.
package mem_handshake_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 13;

endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, combinational read, no reset.
module mem_array
  import mem_handshake_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Valid/ready memory controller with WAIT_CYCLES wait states and range check.
// Define MEM_HANDSHAKE_ERR_EN to add the rsp_err output.
module mem_handshake_ctrl
  import mem_handshake_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
`ifdef MEM_HANDSHAKE_ERR_EN
  output logic              rsp_err,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on the edge where req_valid && req_ready;
  // a response transfers on the edge where rsp_valid && rsp_ready.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  if (64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_depth_check
    $error("mem_handshake_ctrl: DEPTH does not fit in ADDR_W address bits");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              busy_q, busy_d;
  logic              in_range, commit, mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
  // The first cycle spent in RESP is the commit cycle: array write and response load.
  assign commit   = (state_q == RESP) && !rsp_valid_q;
  assign mem_we   = commit && write_q && in_range;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (commit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? wdata_q : (in_range ? mem_rdata : '0);
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MEM_HANDSHAKE_ERR_EN
  logic rsp_err_q, rsp_err_d;

  always_comb begin
    rsp_err_d = rsp_err_q;
    if (commit) rsp_err_d = !in_range;
    else if (rsp_valid_q && rsp_ready) rsp_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsp_err_q <= 1'b0;
    else      rsp_err_q <= rsp_err_d;
  end

  assign rsp_err = rsp_err_q;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Bench for mem_handshake_ctrl: two instances (WAIT_CYCLES=2 and 0) against a word-level memory model.
module tb_mem_handshake_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [12:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_rdata [2];
  logic        busy      [2];
  logic        rsp_err   [2];
  logic [1:0]  dbg       [2];

  int          n_checks;
  int          n_errors;
  int          wc [2];
  logic [15:0] ref_mem [int];
  logic [15:0] exp_q [$];
  logic        err_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  mem_handshake_ctrl #(.WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .busy(busy[0]),
`ifdef MEM_HANDSHAKE_ERR_EN
    .rsp_err(rsp_err[0]),
`endif
    .dbg_state(dbg[0])
  );

  mem_handshake_ctrl #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .busy(busy[1]),
`ifdef MEM_HANDSHAKE_ERR_EN
    .rsp_err(rsp_err[1]),
`endif
    .dbg_state(dbg[1])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check($sformatf("%s_req_ready%0d", tag, k), 32'(req_ready[k]), 32'd1);
    check($sformatf("%s_rsp_valid%0d", tag, k), 32'(rsp_valid[k]), 32'd0);
    check($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 32'd0);
`ifdef MEM_HANDSHAKE_ERR_EN
    check($sformatf("%s_rsp_err%0d", tag, k), 32'(rsp_err[k]), 32'd0);
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with instance k idle; returns at a negedge with k idle again.
  task automatic txn(input int k, input bit wr, input logic [12:0] a, input logic [15:0] d,
                     input int hold, input bit perturb);
    int          lat;
    int          key;
    bit          oor;
    logic [15:0] exp_d;
    logic        exp_e;
    oor = (a >= 13'd256);
    key = k * 65536 + int'(a);
    if (wr) exp_d = d;
    else if (oor) exp_d = 16'h0000;
    else exp_d = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
    if (wr && !oor) ref_mem[key] = d;
    exp_q.push_back(exp_d);
    err_q.push_back(oor);

    check($sformatf("req_ready_before_accept%0d", k), 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 0;
    while (!rsp_valid[k] && lat < 50) begin
      check($sformatf("busy_pending%0d", k), 32'(busy[k]), 32'd1);
      check($sformatf("req_ready_pending%0d", k), 32'(req_ready[k]), 32'd0);
      if (perturb) begin
        req_valid[k] = 1'($urandom_range(0, 1));
        req_write[k] = 1'($urandom_range(0, 1));
        req_addr[k]  = 13'($urandom);
        req_wdata[k] = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    req_valid[k] = 1'b0;
    check($sformatf("latency%0d", k), 32'(lat), 32'(wc[k] + 1));
    exp_d = exp_q.pop_front();
    exp_e = err_q.pop_front();
    check($sformatf("rsp_rdata%0d_a%0d", k, a), 32'(rsp_rdata[k]), 32'(exp_d));
`ifdef MEM_HANDSHAKE_ERR_EN
    check($sformatf("rsp_err%0d_a%0d", k, a), 32'(rsp_err[k]), 32'(exp_e));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("bp_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'd1);
      check($sformatf("bp_rsp_rdata%0d", k), 32'(rsp_rdata[k]), 32'(exp_d));
      check($sformatf("bp_req_ready%0d", k), 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check_idle_outputs(k, "after_rsp");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    n_checks = 0;
    n_errors = 0;
    wc[0] = 2;
    wc[1] = 0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      check_idle_outputs(k, "reset");
      check($sformatf("reset_rdata%0d", k), 32'(rsp_rdata[k]), 32'd0);
      check($sformatf("reset_state%0d", k), 32'(dbg[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Preload a small working set so every later read has a known value.
    for (int a = 0; a < 16; a++)
      for (int k = 0; k < 2; k++)
        txn(k, 1'b1, 13'(a), 16'($urandom), 0, 1'b0);

    // Read after write with two wait states.
    txn(0, 1'b1, 13'd5, 16'h00AA, 0, 1'b0);
    txn(0, 1'b0, 13'd5, 16'h0000, 0, 1'b0);
    // Zero wait states.
    txn(1, 1'b1, 13'd0, 16'd10, 0, 1'b0);
    txn(1, 1'b0, 13'd0, 16'h0000, 0, 1'b0);
    // Backpressure for 4 cycles.
    txn(0, 1'b0, 13'd5, 16'h0000, 4, 1'b0);
    txn(1, 1'b0, 13'd0, 16'h0000, 4, 1'b0);
    // Out of range: 300 aliases 44 in the low bits, so 44 must survive.
    txn(0, 1'b1, 13'd44, 16'h0444, 0, 1'b0);
    txn(0, 1'b1, 13'd300, 16'hFFFF, 0, 1'b0);
    txn(0, 1'b0, 13'd44, 16'h0000, 0, 1'b0);
    txn(0, 1'b0, 13'd300, 16'h0000, 0, 1'b0);
    // Range boundaries.
    txn(0, 1'b1, 13'd255, 16'hBEEF, 0, 1'b0);
    txn(0, 1'b0, 13'd255, 16'h0000, 0, 1'b0);
    txn(1, 1'b1, 13'd256, 16'h5A5A, 1, 1'b0);
    txn(1, 1'b0, 13'd256, 16'h0000, 0, 1'b0);
    txn(1, 1'b1, 13'd8191, 16'h1111, 0, 1'b0);
    txn(1, 1'b0, 13'd8191, 16'h0000, 0, 1'b0);

    // Reset during WAIT discards the pending write.
    txn(0, 1'b1, 13'd7, 16'h0001, 0, 1'b0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 13'd7;
    req_wdata[0] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("mid_wait_busy", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    #1;
    check_idle_outputs(0, "async_reset");
    check("async_reset_rdata", 32'(rsp_rdata[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 13'd7, 16'h0000, 0, 1'b0);

    // Inputs wiggled during WAIT must not leak into the response.
    txn(0, 1'b1, 13'd9, 16'hC0DE, 0, 1'b1);
    txn(0, 1'b0, 13'd9, 16'h0000, 0, 1'b1);
    txn(1, 1'b1, 13'd3, 16'h7777, 0, 1'b1);
    txn(1, 1'b0, 13'd3, 16'h0000, 0, 1'b1);

    // Random traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 4));
      txn(i % 2, 1'($urandom_range(0, 1)),
          (r == 0) ? 13'($urandom_range(256, 8191)) : 13'($urandom_range(0, 15)),
          16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
